// File: rtl/bam_div_pkg.sv
// Shared types and helpers for the BAM sequential divider and its companion
// multiplier models.
package bam_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MASK_MAX_W    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Keep-mask for operand LSBs at or above the break level, limited to width bits.
  function automatic logic [MASK_MAX_W-1:0] vbl_mask(input int unsigned width,
                                                      input int unsigned vbl);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
      m[i] = (i >= vbl) && (i < width);
    end
    return m;
  endfunction

endpackage

// File: rtl/div_restore_cell.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor when the partial remainder allows it.
module div_restore_cell
  import bam_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             qbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_n,
  output logic             qbit_out
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // The difference is below the divisor whenever it is taken, so WIDTH bits suffice.
  always_comb begin
    trial    = {rem, qbit};
    diff     = trial[WIDTH-1:0] - divisor;
    qbit_out = (trial >= {1'b0, divisor});
    rem_n    = qbit_out ? diff : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/bam_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, with optional
// dividend LSB truncation below the break level VBL.
module bam_seq_divider
  import bam_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned VBL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] KEEP_MASK = WIDTH'(vbl_mask(WIDTH, VBL));

  if (VBL >= WIDTH) begin : g_bad_vbl
    $error("bam_seq_divider: VBL must be below WIDTH");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("bam_seq_divider: WIDTH must be at least 2");
  end

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic             dz_q;

  logic             accept_c;
  logic             step_c;
  logic             finish_c;
  logic [WIDTH-1:0] rem_next_c;
  logic             qbit_c;
  logic [WIDTH-1:0] q_shift_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = CALC;
      CALC:    if (cnt_q == '0)   state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: accept_c = in_valid;
      CALC: begin
        step_c   = 1'b1;
        finish_c = (cnt_q == '0);
      end
      default: ;
    endcase
  end

  div_restore_cell #(.WIDTH(WIDTH)) u_cell (
    .rem      (rem_q),
    .qbit     (q_q[WIDTH-1]),
    .divisor  (d_q),
    .rem_n    (rem_next_c),
    .qbit_out (qbit_c)
  );

  assign q_shift_c = {q_q[WIDTH-2:0], qbit_c};

  // Working registers: q doubles as the dividend shifter and the quotient accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      q_q   <= '0;
      d_q   <= '0;
      dz_q  <= 1'b0;
    end else if (accept_c) begin
      cnt_q <= CNT_W'(WIDTH - 1);
      rem_q <= '0;
      q_q   <= dividend & KEEP_MASK;
      d_q   <= divisor;
      dz_q  <= (divisor == '0);
    end else if (step_c) begin
      cnt_q <= cnt_q - CNT_W'(1);
      rem_q <= rem_next_c;
      q_q   <= q_shift_c;
    end
  end

  // Handshake flags track the next state; results update only when the last step lands
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (finish_c) begin
        quotient    <= q_shift_c;
        remainder   <= rem_next_c;
        div_by_zero <= dz_q;
      end
    end
  end

endmodule
